// File: rtl/proto_sort_pkg.sv
// -----------------------------------------------------------------------------
// proto_sort_pkg
// Shared definitions for the proto_sort feeder path: the sequencer state
// encoding, the default element width and the slot/select geometry of the
// four-way output mux.
// -----------------------------------------------------------------------------
package proto_sort_pkg;

  // Sequencer states: wait for a set, run the sorting passes, hand out slots.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    EMIT = 2'd2
  } state_e;

  // Default element width; must match the data width of the downstream mux.
  localparam int DEFAULT_WIDTH = 4;

  // Number of sorted slots and the width of the mux select that walks them.
  localparam int SLOTS = 4;
  localparam int SEL_W = 2;

endpackage : proto_sort_pkg

// File: rtl/sort4_sequencer_cmp_swap.sv
// -----------------------------------------------------------------------------
// cmp_swap
// Combinational compare-exchange element of the odd-even transposition network.
// Routes the pair (a, b) so that 'lo' feeds the lower-numbered slot and 'hi'
// the higher-numbered slot in the requested order.
//
// Ports:
//   a, b   in  WIDTH  operands; a comes from the lower-numbered slot
//   desc   in  1      0 = ascending (lo gets the smaller), 1 = descending
//   lo     out WIDTH  value for the lower-numbered slot
//   hi     out WIDTH  value for the higher-numbered slot
// -----------------------------------------------------------------------------
module cmp_swap #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             desc,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic swap;

  always_comb begin
    // Strict comparison only: equal operands keep their positions, which
    // keeps the network stable and avoids pointless toggling.
    swap = desc ? (a < b) : (a > b);
    lo   = swap ? b : a;
    hi   = swap ? a : b;
  end

endmodule : cmp_swap

// File: rtl/sort4_sequencer.sv
// -----------------------------------------------------------------------------
// sort4_sequencer
// Upstream feeder for the four-way output mux of proto_sort. Captures a set of
// four elements with a valid/ready handshake, sorts them in place with an
// odd-even transposition network (one pass per clock), then presents the
// sorted slots on the mux data inputs and steps the mux select 0..3 under an
// output handshake so the mux emits the values in sorted order.
//
// Ports:
//   clk        in  1      system clock, rising edge
//   rst_n      in  1      asynchronous active-low reset
//   in_valid   in  1      input set present on din0..din3
//   in_ready   out 1      block can accept a new set (IDLE)
//   din0..3    in  WIDTH  input elements
//   zero..three out WIDTH sorted slots 0..3, to the mux data inputs
//   sel        out 2      mux select
//   out_valid  out 1      mux output (slot indexed by sel) is valid (EMIT)
//   out_ready  in  1      downstream accepts the current element
//   last       out 1      current element is slot 3
//   busy       out 1      SORT or EMIT in progress
//
// Every output is a register or a decode of registered state only; neither
// in_valid nor out_ready reaches an output combinationally.
// -----------------------------------------------------------------------------
module sort4_sequencer
  import proto_sort_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter bit DESCEND = 1'b0,
  parameter int PASSES  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic [WIDTH-1:0] din3,
  output logic [WIDTH-1:0] zero,
  output logic [WIDTH-1:0] one,
  output logic [WIDTH-1:0] two,
  output logic [WIDTH-1:0] three,
  output logic [SEL_W-1:0] sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             last,
  output logic             busy
);

  // Pass counter only has to reach PASSES-1.
  localparam int CNT_W = (PASSES > 2) ? $clog2(PASSES) : 1;
  localparam logic [CNT_W-1:0] LAST_PASS = CNT_W'(PASSES - 1);
  localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(SLOTS - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] slot_q [SLOTS];
  logic [WIDTH-1:0] slot_d [SLOTS];
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [SEL_W-1:0] sel_q,  sel_d;

  // ---------------------------------------------------------------------------
  // Compare-exchange network. Even passes use pairs (0,1) and (2,3); odd
  // passes use the middle pair (1,2). All three comparators evaluate every
  // cycle; the FSM picks which results are written back.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] lo01, hi01, lo23, hi23, lo12, hi12;

  cmp_swap #(.WIDTH(WIDTH)) u_cmp01 (
    .a    (slot_q[0]),
    .b    (slot_q[1]),
    .desc (DESCEND),
    .lo   (lo01),
    .hi   (hi01)
  );

  cmp_swap #(.WIDTH(WIDTH)) u_cmp23 (
    .a    (slot_q[2]),
    .b    (slot_q[3]),
    .desc (DESCEND),
    .lo   (lo23),
    .hi   (hi23)
  );

  cmp_swap #(.WIDTH(WIDTH)) u_cmp12 (
    .a    (slot_q[1]),
    .b    (slot_q[2]),
    .desc (DESCEND),
    .lo   (lo12),
    .hi   (hi12)
  );

  // ---------------------------------------------------------------------------
  // Next-state and datapath update.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case statement leaves one unassigned, which would infer a latch.
    state_d = state_q;
    slot_d  = slot_q;
    pass_d  = pass_q;
    sel_d   = sel_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          slot_d[0] = din0;
          slot_d[1] = din1;
          slot_d[2] = din2;
          slot_d[3] = din3;
          pass_d    = '0;
          state_d   = SORT;
        end
      end

      SORT: begin
        if (!pass_q[0]) begin
          slot_d[0] = lo01;
          slot_d[1] = hi01;
          slot_d[2] = lo23;
          slot_d[3] = hi23;
        end else begin
          slot_d[1] = lo12;
          slot_d[2] = hi12;
        end

        if (pass_q == LAST_PASS) begin
          state_d = EMIT;
          sel_d   = '0;
        end else begin
          pass_d = pass_q + CNT_W'(1);
        end
      end

      EMIT: begin
        // Slots are frozen here; only the select moves, and only on a
        // handshake. The 3 -> 0 wrap happens solely on the exit to IDLE.
        if (out_ready) begin
          if (sel_q == LAST_SEL) begin
            sel_d   = '0;
            state_d = IDLE;
          end else begin
            sel_d = sel_q + SEL_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pass_q  <= '0;
      sel_q   <= '0;
      // NOTE: the slot registers drive the mux directly and must read zero
      // after reset, so this small array is reset like any other flop rather
      // than being treated as an unreset storage memory.
      for (int i = 0; i < SLOTS; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      pass_q  <= pass_d;
      sel_q   <= sel_d;
      slot_q  <= slot_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: registers and state decodes only.
  // ---------------------------------------------------------------------------
  assign zero      = slot_q[0];
  assign one       = slot_q[1];
  assign two       = slot_q[2];
  assign three     = slot_q[3];
  assign sel       = sel_q;
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign last      = (state_q == EMIT) && (sel_q == LAST_SEL);
  assign busy      = (state_q != IDLE);

endmodule : sort4_sequencer
